// File: rtl/hzd_pkg.sv
// hzd_pkg: shared types and constants for the u_hzd pipeline hazard controller.
//   hzd_st_t    - controller states RUN / MEMW / FLUSH
//   FCNT_W      - width of the flush-bubble counter
//   hzd_fcyc_ok - legal range check for FLUSH_CYC (1..7)
package hzd_pkg;

    typedef enum logic [1:0] {RUN, MEMW, FLUSH} hzd_st_t;

    localparam int FCNT_W = 3;

    function automatic bit hzd_fcyc_ok(int n);
        return (n >= 1) && (n <= 7);
    endfunction

endpackage

// File: rtl/u_hzd_perf.sv
// u_hzd_perf: 32-bit wrapping performance counters for the hazard controller.
//   clk, rstn     - core clock, asynchronous active-low reset
//   mem_busy      - memory-wait cycle event
//   luse          - load-use stall cycle event
//   redir         - fetch redirect pulse
//   perf_memw/luse/redir - event counts since reset
module u_hzd_perf (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_busy,
    input  logic        luse,
    input  logic        redir,
    output logic [31:0] perf_memw,
    output logic [31:0] perf_luse,
    output logic [31:0] perf_redir
);

    logic [31:0] memw_q, luse_q, redir_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            memw_q  <= '0;
            luse_q  <= '0;
            redir_q <= '0;
        end else begin
            memw_q  <= memw_q + {31'd0, mem_busy};
            luse_q  <= luse_q + {31'd0, luse};
            redir_q <= redir_q + {31'd0, redir};
        end
    end

    assign perf_memw  = memw_q;
    assign perf_luse  = luse_q;
    assign perf_redir = redir_q;

endmodule

// File: rtl/u_hzd.sv
// u_hzd: execute-pipeline hazard controller (memory wait, load-use, taken branch).
//   FLUSH_CYC      - flush0 bubble cycles per redirect, redirect cycle included (1..7)
//   clk, rstn      - core clock, asynchronous active-low reset
//   branch         - taken control transfer resolved in execute
//   fwd_no_dat     - execute source operand not yet available
//   lsu_re, lsu_we - registered stage-2 LSU byte enables
//   lsu_vld        - LSU access completes this cycle
//   flush0/flush1  - clear execute input / stage-2 registers
//   stall0/1/2     - hold execute input / stage-2 / stage-3 registers
//   ifu_stall      - hold fetch PC and decode output
//   ifu_redirect   - load branch target into fetch PC
//   perf_memw/luse/redir - event counters, present only with HZD_PERF_EN defined
module u_hzd
    import hzd_pkg::*;
#(
    parameter int FLUSH_CYC = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        branch,
    input  logic        fwd_no_dat,
    input  logic [3:0]  lsu_re,
    input  logic [3:0]  lsu_we,
    input  logic        lsu_vld,
    output logic        flush0,
    output logic        flush1,
    output logic        stall0,
    output logic        stall1,
    output logic        stall2,
    output logic        ifu_stall,
    output logic        ifu_redirect
`ifdef HZD_PERF_EN
    ,
    output logic [31:0] perf_memw,
    output logic [31:0] perf_luse,
    output logic [31:0] perf_redir
`endif
);

    if (!hzd_fcyc_ok(FLUSH_CYC)) begin : g_bad_fcyc
        $error("u_hzd: FLUSH_CYC must be in 1..7");
    end

    hzd_st_t             st_q, st_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                mem_busy, hold, luse, fl, redir;

    assign mem_busy = (|lsu_re | |lsu_we) & ~lsu_vld;

    always_comb begin
        st_d   = st_q;
        fcnt_d = fcnt_q;
        hold   = 1'b0;
        luse   = 1'b0;
        fl     = 1'b0;
        redir  = 1'b0;
        case (st_q)
            RUN: begin
                if (mem_busy) begin
                    hold = 1'b1;
                    st_d = MEMW;
                end else if (fwd_no_dat) begin
                    luse = 1'b1;
                end else if (branch) begin
                    fl    = 1'b1;
                    redir = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        fcnt_d = FCNT_W'(FLUSH_CYC - 1);
                        st_d   = FLUSH;
                    end
                end
            end
            MEMW: begin
                hold = ~lsu_vld;
                if (lsu_vld) st_d = RUN;
            end
            FLUSH: begin
                fl = 1'b1;
                // a memory wait freezes the bubble count so no bubble is lost
                if (mem_busy) begin
                    hold = 1'b1;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                    if (fcnt_q == FCNT_W'(1)) st_d = RUN;
                end
            end
            default: st_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q   <= RUN;
            fcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            fcnt_q <= fcnt_d;
        end
    end

    // stall chain is structural: stall2 implies stall1 implies stall0
    assign flush0       = fl;
    assign flush1       = luse;
    assign stall0       = hold | luse;
    assign stall1       = hold;
    assign stall2       = hold;
    assign ifu_stall    = hold | luse;
    assign ifu_redirect = redir;

`ifdef HZD_PERF_EN
    u_hzd_perf u_perf (
        .clk        (clk),
        .rstn       (rstn),
        .mem_busy   (mem_busy),
        .luse       (luse),
        .redir      (redir),
        .perf_memw  (perf_memw),
        .perf_luse  (perf_luse),
        .perf_redir (perf_redir)
    );
`endif

endmodule
